// File: rtl/bus_gate_arb_if.sv
// bus_gate_arb_if: source data, drive requests and shared-bus status between the sources and the arbiter
interface bus_gate_arb_if #(
    parameter int WIDTH = 16,
    parameter int NSRC  = 4
);
    logic [NSRC*WIDTH-1:0] d_in;
    logic [NSRC-1:0]       gate;
    logic                  clr_err;
    logic [WIDTH-1:0]      bus_out;
    logic [NSRC-1:0]       owner;
    logic                  bus_valid;
    logic                  contention;

    modport master (
        output d_in, gate, clr_err,
        input  bus_out, owner, bus_valid, contention
    );

    modport slave (
        input  d_in, gate, clr_err,
        output bus_out, owner, bus_valid, contention
    );
endinterface

// File: rtl/bus_gate_arb.sv
// bus_gate_arb: fixed-priority tristate bus arbiter with one-cycle turnaround; BUS_GATE_KEEPER_EN adds a bus keeper
module bus_gate_arb #(
    parameter int WIDTH = 16,
    parameter int NSRC  = 4
) (
    input logic         clk,
    input logic         reset,
    bus_gate_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_e;

    state_e            state_q, state_d;
    logic [NSRC-1:0]   owner_q, owner_d, winner;
    logic              contention_q, contention_d, multi;
    logic [WIDTH-1:0]  sel;

    // lowest-index requester wins arbitration
    always_comb begin
        winner = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (bus.gate[i]) begin
                winner    = '0;
                winner[i] = 1'b1;
            end
    end

    assign multi = |(bus.gate & (bus.gate - {{(NSRC-1){1'b0}}, 1'b1}));

    // data slice of the current owner
    always_comb begin
        sel = '0;
        for (int i = 0; i < NSRC; i++)
            if (owner_q[i]) sel = bus.d_in[i*WIDTH +: WIDTH];
    end

    // next state: owner holds the bus until it drops its request; contention only sampled at arbitration points
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        contention_d = contention_q & ~bus.clr_err;
        if (state_q == DRIVE) begin
            if (!(|(bus.gate & owner_q))) begin
                state_d = (|bus.gate) ? TURN : IDLE;
                owner_d = '0;
            end
        end else begin
            state_d = (|bus.gate) ? DRIVE : IDLE;
            owner_d = winner;
            if (multi) contention_d = 1'b1;
        end
    end

    // state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            contention_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            contention_q <= contention_d;
        end
    end

`ifdef BUS_GATE_KEEPER_EN
    logic [WIDTH-1:0] hold_q, hold_d;

    // keeper follows the bus while driven
    always_comb hold_d = (state_q == DRIVE) ? sel : hold_q;

    // keeper register
    always_ff @(posedge clk) hold_q <= reset ? '0 : hold_d;

    assign bus.bus_out = (state_q == DRIVE) ? sel : hold_q;
`else
    assign bus.bus_out = (state_q == DRIVE) ? sel : {WIDTH{1'bz}};
`endif

    assign bus.owner      = owner_q;
    assign bus.bus_valid  = (state_q == DRIVE);
    assign bus.contention = contention_q;
endmodule

// File: tb/tb_bus_gate_arb.sv
// tb_bus_gate_arb: directed and randomized checks of bus_gate_arb against a source-index reference model
module tb_bus_gate_arb;
    localparam int W = 16;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   passed = 0;

    logic [W-1:0] zv = 'z;
    int           m_own = -1;
    logic         m_cont = 1'b0;
    logic [W-1:0] m_hold = '0;

    bus_gate_arb_if #(.WIDTH(W), .NSRC(N)) bif ();

    bus_gate_arb #(.WIDTH(W), .NSRC(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] idle_val();
`ifdef BUS_GATE_KEEPER_EN
        return m_hold;
`else
        return zv;
`endif
    endfunction

    // one clock edge with the given inputs; the model tracks the owning source index
    task automatic step(input logic [N-1:0] g, input logic clr, input logic rst);
        int low;
        bif.gate    = g;
        bif.clr_err = clr;
        reset       = rst;
        @(posedge clk);
        low = -1;
        for (int i = N - 1; i >= 0; i--) if (g[i]) low = i;
        if (rst) begin
            m_own = -1; m_cont = 1'b0; m_hold = '0;
        end else if (m_own < 0) begin
            m_cont = ($countones(g) >= 2) || (m_cont && !clr);
            m_own  = low;
        end else begin
            m_cont = m_cont && !clr;
            m_hold = bif.d_in[m_own*W +: W];
            if (!g[m_own]) m_own = -1;
        end
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bif.d_in = '0;
        step('0, 1'b0, 1'b1);
        total++;
        if ({bif.owner, bif.bus_valid, bif.contention} !== 6'b0) $display("FAIL reset: owner/valid/cont=%b expected 000000", {bif.owner, bif.bus_valid, bif.contention});
        else passed++;
    endtask

    task automatic test_single();
        bif.d_in[0 +: W] = 16'h3000;
        for (int k = 0; k < 3; k++) begin
            step(4'b0001, 1'b0, 1'b0);
            total++;
            if ({bif.bus_out, bif.owner, bif.bus_valid} !== {16'h3000, 4'b0001, 1'b1}) $display("FAIL single_drive: bus=%h owner=%b valid=%b expected 3000 0001 1", bif.bus_out, bif.owner, bif.bus_valid);
            else passed++;
        end
        step('0, 1'b0, 1'b0);
        total++;
        if ({bif.bus_out, bif.bus_valid, bif.contention} !== {idle_val(), 2'b00}) $display("FAIL single_release: bus=%h valid=%b cont=%b expected %h 0 0", bif.bus_out, bif.bus_valid, bif.contention, idle_val());
        else passed++;
    endtask

    task automatic test_handover();
        bif.d_in[1*W +: W] = 16'h1111;
        bif.d_in[2*W +: W] = 16'h2222;
        step(4'b0010, 1'b0, 1'b0);
        total++;
        if ({bif.bus_out, bif.owner} !== {16'h1111, 4'b0010}) $display("FAIL handover_first: bus=%h owner=%b expected 1111 0010", bif.bus_out, bif.owner);
        else passed++;
        step(4'b0100, 1'b0, 1'b0);
        total++;
        if ({bif.bus_out, bif.owner, bif.bus_valid} !== {idle_val(), 4'b0000, 1'b0}) $display("FAIL handover_turn: bus=%h owner=%b valid=%b expected %h 0000 0", bif.bus_out, bif.owner, bif.bus_valid, idle_val());
        else passed++;
        step(4'b0100, 1'b0, 1'b0);
        total++;
        if ({bif.bus_out, bif.owner, bif.bus_valid} !== {16'h2222, 4'b0100, 1'b1}) $display("FAIL handover_second: bus=%h owner=%b valid=%b expected 2222 0100 1", bif.bus_out, bif.owner, bif.bus_valid);
        else passed++;
        step('0, 1'b0, 1'b0);
    endtask

    task automatic test_contention();
        step(4'b1010, 1'b0, 1'b0);
        total++;
        if ({bif.owner, bif.contention} !== 5'b0010_1) $display("FAIL contention_set: owner=%b cont=%b expected 0010 1", bif.owner, bif.contention);
        else passed++;
        step('0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        total++;
        if (bif.contention !== 1'b1) $display("FAIL contention_sticky: cont=%b expected 1", bif.contention);
        else passed++;
        step('0, 1'b1, 1'b0);
        total++;
        if (bif.contention !== 1'b0) $display("FAIL contention_clear: cont=%b expected 0", bif.contention);
        else passed++;
        step(4'b0011, 1'b1, 1'b0);
        total++;
        if ({bif.owner, bif.contention} !== 5'b0001_1) $display("FAIL contention_set_wins: owner=%b cont=%b expected 0001 1", bif.owner, bif.contention);
        else passed++;
        step('0, 1'b0, 1'b0);
        step('0, 1'b1, 1'b0);
    endtask

    task automatic test_no_preempt();
        step(4'b0100, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(4'b0101, 1'b0, 1'b0);
            total++;
            if ({bif.owner, bif.contention} !== 5'b0100_0) $display("FAIL no_preempt: owner=%b cont=%b expected 0100 0", bif.owner, bif.contention);
            else passed++;
        end
        step('0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_drive();
        bif.d_in[3*W +: W] = 16'h7777;
        step(4'b1000, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b1);
        total++;
        if ({bif.bus_out, bif.owner, bif.bus_valid} !== {idle_val(), 4'b0000, 1'b0}) $display("FAIL reset_mid_drive: bus=%h owner=%b valid=%b expected %h 0000 0", bif.bus_out, bif.owner, bif.bus_valid, idle_val());
        else passed++;
        step('0, 1'b0, 1'b0);
    endtask

    task automatic test_keeper();
        bif.d_in[1*W +: W] = 16'hBEEF;
        step(4'b0010, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        bif.d_in[1*W +: W] = 16'h0123;
        #1;
        total++;
`ifdef BUS_GATE_KEEPER_EN
        if ({bif.bus_out, bif.bus_valid} !== {16'hBEEF, 1'b0}) $display("FAIL keeper_hold: bus=%h valid=%b expected beef 0", bif.bus_out, bif.bus_valid);
`else
        if ({bif.bus_out, bif.bus_valid} !== {zv, 1'b0}) $display("FAIL keeper_hold: bus=%h valid=%b expected zzzz 0", bif.bus_out, bif.bus_valid);
`endif
        else passed++;
    endtask

    task automatic test_random();
        logic [N-1:0] g;
        logic [W-1:0] exp_bus;
        for (int k = 0; k < 400; k++) begin
            bif.d_in = {$urandom, $urandom};
            g = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
            step(g, $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
            exp_bus = (m_own >= 0) ? bif.d_in[m_own*W +: W] : idle_val();
            total++;
            if ({bif.bus_out, bif.owner, bif.bus_valid, bif.contention} !== {exp_bus, (m_own >= 0) ? N'(1) << m_own : N'(0), m_own >= 0, m_cont})
                $display("FAIL random[%0d]: bus=%h owner=%b valid=%b cont=%b expected %h own_idx=%0d cont=%b", k, bif.bus_out, bif.owner, bif.bus_valid, bif.contention, exp_bus, m_own, m_cont);
            else passed++;
        end
    endtask

    initial begin
        bif.gate = '0;
        bif.clr_err = 1'b0;
        bif.d_in = '0;
        test_reset();
        test_single();
        test_handover();
        test_contention();
        test_no_preempt();
        test_reset_mid_drive();
        test_keeper();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
